// File: rtl/bram_sync_ctrl.sv
// ---------------------------------------------------------------------------
// bram_sync_ctrl
//
// Purpose:
//   Moves a backup-RAM save slot between the core and a sector-based save
//   medium. A load or save walks all SECTORS sectors of the selected slot
//   using an rd/wr + ack handshake. A format writes a fixed 4-word header
//   through a dedicated write port.
//
// Optional feature (macro BRAM_AUTOSAVE_EN):
//   Core writes into backup RAM mark the slot dirty. After AUTOSAVE_DELAY
//   idle cycles without another write, a save starts automatically. Without
//   the macro, dirty is constant 0 and bram_we is ignored.
//
// Ports:
//   clk_sys                       system clock, rising edge
//   reset                         asynchronous, active-high reset
//   bk_ena                        save medium mounted and writable
//   load_req/save_req/format_req  level requests, acted on at their rise
//   slot                          slot select, sampled when a transfer starts
//   bram_we                       core write strobe into backup RAM
//   sd_lba/sd_rd/sd_wr/sd_ack     sector handshake to the save medium
//   busy/loading/dirty            status (loading holds the core in reset)
//   fmt_addr/fmt_data/fmt_we      format header write port
// ---------------------------------------------------------------------------
module bram_sync_ctrl #(
    parameter int          SECTORS        = 16,
    parameter int          SLOT_BITS      = 2,
    parameter logic [23:0] AUTOSAVE_DELAY = 24'd5000000
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 bk_ena,
    input  logic                 load_req,
    input  logic                 save_req,
    input  logic                 format_req,
    input  logic [SLOT_BITS-1:0] slot,
    input  logic                 bram_we,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    output logic                 busy,
    output logic                 loading,
    output logic                 dirty,
    output logic [1:0]           fmt_addr,
    output logic [15:0]          fmt_data,
    output logic                 fmt_we
);

    localparam int          SECTOR_BITS = $clog2(SECTORS);
    localparam logic [31:0] SECTOR_MASK = 32'(SECTORS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_FORMAT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] lba_q, lba_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        busy_q, busy_d;
    logic        loading_q, loading_d;
    logic        dirty_q, dirty_d;
    logic        fmt_we_q, fmt_we_d;
    logic [1:0]  fmt_addr_q, fmt_addr_d;
    logic [15:0] fmt_data_q, fmt_data_d;
    logic        load_req_q, save_req_q, format_req_q, ack_q;

    logic        load_rise, save_rise, format_rise, ack_rise, ack_fall;
    logic [31:0] start_lba;
    logic        last_sector;

    // Header words of a freshly formatted save slot, indexed by address.
    function automatic logic [15:0] fmt_word(input logic [1:0] addr);
        case (addr)
            2'd0:    fmt_word = 16'h5548;
            2'd1:    fmt_word = 16'h4D42;
            2'd2:    fmt_word = 16'h8800;
            default: fmt_word = 16'h8010;
        endcase
    endfunction

    assign load_rise   = load_req   & ~load_req_q;
    assign save_rise   = save_req   & ~save_req_q;
    assign format_rise = format_req & ~format_req_q;
    assign ack_rise    = sd_ack     & ~ack_q;
    assign ack_fall    = ~sd_ack    &  ack_q;

    // The slot occupies the bits above the sector field, sector starts at 0.
    assign start_lba   = 32'(slot) << SECTOR_BITS;
    assign last_sector = (lba_q & SECTOR_MASK) == SECTOR_MASK;

`ifdef BRAM_AUTOSAVE_EN
    logic [23:0] cnt_q, cnt_d;
    logic        autosave_fire;

    // Fires on the cycle the idle count would reach AUTOSAVE_DELAY.
    assign autosave_fire = dirty_q && bk_ena && !bram_we &&
                           (cnt_q == AUTOSAVE_DELAY - 24'd1);
`else
    logic unused_autosave;
    assign unused_autosave = &{1'b0, bram_we, AUTOSAVE_DELAY};
`endif

    // Next-state and output computation. Explicit requests are only honoured
    // from IDLE; anything that rises while busy is consumed by the edge
    // registers and therefore dropped.
    always_comb begin
        state_d    = state_q;
        lba_d      = lba_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        busy_d     = busy_q;
        loading_d  = loading_q;
        dirty_d    = dirty_q;
        fmt_we_d   = fmt_we_q;
        fmt_addr_d = fmt_addr_q;
        fmt_data_d = fmt_data_q;

        case (state_q)
            ST_IDLE: begin
                if (bk_ena && load_rise) begin
                    state_d   = ST_XFER;
                    lba_d     = start_lba;
                    rd_d      = 1'b1;
                    busy_d    = 1'b1;
                    loading_d = 1'b1;
                end else if (bk_ena && save_rise) begin
                    state_d = ST_XFER;
                    lba_d   = start_lba;
                    wr_d    = 1'b1;
                    busy_d  = 1'b1;
                end else if (format_rise) begin
                    state_d    = ST_FORMAT;
                    fmt_we_d   = 1'b1;
                    fmt_addr_d = 2'd0;
                    fmt_data_d = fmt_word(2'd0);
`ifdef BRAM_AUTOSAVE_EN
                end else if (autosave_fire) begin
                    state_d = ST_XFER;
                    lba_d   = start_lba;
                    wr_d    = 1'b1;
                    busy_d  = 1'b1;
`endif
                end
            end

            // Strobe drops once the medium acknowledges; the ack release
            // either finishes the slot or advances to the next sector
            // without disturbing the slot bits.
            ST_XFER: begin
                if (ack_rise) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                end else if (ack_fall) begin
                    if (last_sector) begin
                        state_d   = ST_IDLE;
                        busy_d    = 1'b0;
                        loading_d = 1'b0;
                        dirty_d   = 1'b0;
                    end else begin
                        lba_d = (lba_q & ~SECTOR_MASK) |
                                ((lba_q + 32'd1) & SECTOR_MASK);
                        rd_d  = loading_q;
                        wr_d  = ~loading_q;
                    end
                end
            end

            ST_FORMAT: begin
                if (fmt_addr_q == 2'd3) begin
                    state_d    = ST_IDLE;
                    fmt_we_d   = 1'b0;
                    fmt_addr_d = 2'd0;
                    fmt_data_d = 16'h0000;
`ifdef BRAM_AUTOSAVE_EN
                    dirty_d    = 1'b1;
`endif
                end else begin
                    fmt_addr_d = fmt_addr_q + 2'd1;
                    fmt_data_d = fmt_word(fmt_addr_q + 2'd1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef BRAM_AUTOSAVE_EN
        // A core write always marks the slot dirty and restarts the idle
        // count; the count only runs while settled in IDLE with a dirty,
        // writable medium.
        cnt_d = cnt_q;
        if (bram_we) begin
            dirty_d = 1'b1;
        end
        if (bram_we || state_q != ST_IDLE || state_d != ST_IDLE) begin
            cnt_d = 24'd0;
        end else if (dirty_q && bk_ena) begin
            cnt_d = cnt_q + 24'd1;
        end
`endif
    end

    // State and output registers, plus the request/ack edge registers.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            lba_q        <= 32'd0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            busy_q       <= 1'b0;
            loading_q    <= 1'b0;
            dirty_q      <= 1'b0;
            fmt_we_q     <= 1'b0;
            fmt_addr_q   <= 2'd0;
            fmt_data_q   <= 16'h0000;
            load_req_q   <= 1'b0;
            save_req_q   <= 1'b0;
            format_req_q <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            lba_q        <= lba_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            busy_q       <= busy_d;
            loading_q    <= loading_d;
            dirty_q      <= dirty_d;
            fmt_we_q     <= fmt_we_d;
            fmt_addr_q   <= fmt_addr_d;
            fmt_data_q   <= fmt_data_d;
            load_req_q   <= load_req;
            save_req_q   <= save_req;
            format_req_q <= format_req;
            ack_q        <= sd_ack;
        end
    end

`ifdef BRAM_AUTOSAVE_EN
    // Idle cycle counter for the autosave timer.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_q <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign sd_lba   = lba_q;
    assign sd_rd    = rd_q;
    assign sd_wr    = wr_q;
    assign busy     = busy_q;
    assign loading  = loading_q;
    assign dirty    = dirty_q;
    assign fmt_we   = fmt_we_q;
    assign fmt_addr = fmt_addr_q;
    assign fmt_data = fmt_data_q;

endmodule

// File: doc/bram_sync_ctrl.md
BRAM_SYNC_CTRL -- requirements
Module: bram_sync_ctrl

Interface
REQ-001 SHALL have parameter SECTORS, default 16: sectors per save slot; power of two, 2..256.
REQ-002 SHALL have parameter SLOT_BITS, default 2: width of the slot select (2^SLOT_BITS slots).
REQ-003 SHALL have parameter AUTOSAVE_DELAY, default 24'd5000000: idle cycles before an autosave (used only with BRAM_AUTOSAVE_EN).
REQ-004 SHALL have port clk_sys  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port bk_ena  in  1  save medium mounted and writable; requests ignored when 0.
REQ-007 SHALL have ports load_req, save_req, format_req  in  1 each  level inputs, acted on at rising edge.
REQ-008 SHALL have port slot  in  SLOT_BITS  slot select, sampled when a transfer starts.
REQ-009 SHALL have port bram_we  in  1  core write strobe into backup RAM (dirty tracking).
REQ-010 SHALL have ports sd_lba  out  32, sd_rd  out  1, sd_wr  out  1, sd_ack  in  1  sector handshake.
REQ-011 SHALL have ports busy  out  1, loading  out  1 (holds core in reset), dirty  out  1.
REQ-012 SHALL have ports fmt_addr  out  2, fmt_data  out  16, fmt_we  out  1  format header write port.

Function
REQ-013 SHALL register load_req, save_req, format_req and sd_ack each cycle for edge detection.
REQ-014 SHALL implement states IDLE, XFER and FORMAT.
REQ-015 In IDLE with bk_ena=1, a simultaneous load/save/format rise SHALL resolve with priority load > save > format.
REQ-016 A load or save start SHALL set sd_lba = {slot, log2(SECTORS) zero bits}, zero-extended to 32 bits.
REQ-017 A load start SHALL set sd_rd=1, loading=1, busy=1; a save start SHALL set sd_wr=1, busy=1; both SHALL enter XFER on the next edge.
REQ-018 sd_rd and sd_wr SHALL clear on the cycle after a registered sd_ack rising edge.
REQ-019 On an sd_ack falling edge in XFER: if the sector field is all ones, the block SHALL return to IDLE with busy=0, loading=0 and dirty=0.
REQ-020 On an sd_ack falling edge in XFER otherwise: sd_lba SHALL increment by 1 and the same strobe (rd or wr) SHALL reassert on the next cycle.
REQ-021 The slot bits of sd_lba SHALL NOT change during XFER; the sector field SHALL NOT carry into them.
REQ-022 FORMAT SHALL last exactly 4 cycles with fmt_we=1, fmt_addr=0..3, and fmt_data=16'h5548, 16'h4D42, 16'h8800, 16'h8010; it SHALL then set dirty and return to IDLE.
REQ-023 fmt_we SHALL be 0 outside FORMAT.
REQ-024 Requests arriving while busy=1 or in FORMAT SHALL be dropped, not queued.
REQ-025 Format SHALL NOT require bk_ena.
REQ-026 A bk_ena fall during XFER SHALL NOT abort the transfer.

Reset
REQ-027 Asserting reset SHALL immediately set state=IDLE; sd_lba=0; sd_rd, sd_wr, busy, loading, dirty, fmt_we=0; fmt_addr=0; fmt_data=0; all edge registers=0; autosave counter=0.
REQ-028 Reset during XFER SHALL abandon the transfer with no further strobes issued.

Configuration
REQ-029 With BRAM_AUTOSAVE_EN defined: bram_we=1 SHALL set dirty and clear the idle counter.
REQ-030 With BRAM_AUTOSAVE_EN defined: in IDLE with dirty=1 and bk_ena=1, the counter SHALL count cycles without bram_we, and on reaching AUTOSAVE_DELAY SHALL start a save per REQ-016/017 and reset to 0.
REQ-031 With BRAM_AUTOSAVE_EN defined, an explicit request in the same cycle SHALL take priority over autosave.
REQ-032 Without BRAM_AUTOSAVE_EN, dirty SHALL be constant 0, no counter SHALL exist, and bram_we SHALL be ignored.

Verification
REQ-033 SECTORS=16, slot=2, load rise, ack responder -> sd_lba 32'h20..32'h2F, 16 sd_rd pulses, loading=1 throughout, busy=0 after the 16th ack fall.
REQ-034 Save slot=3 -> sd_wr pulses only, final sd_lba=32'h3F, sd_rd never 1.
REQ-035 Format rise -> 4 consecutive fmt_we cycles with addr 0..3 and data 5548/4D42/8800/8010; dirty=1 only when BRAM_AUTOSAVE_EN is defined.
REQ-036 load_req and save_req rise together -> load performed; a save_req rise during XFER -> ignored, no extra sectors transferred.
REQ-037 Reset asserted after sector 5 ack -> all outputs 0 immediately; a new load after release starts at sector 0.
REQ-038 BRAM_AUTOSAVE_EN, AUTOSAVE_DELAY=100, bram_we pulse -> save starts exactly 100 idle cycles later; a bram_we at cycle 50 restarts the count.
